mul_div_unit: RTL and testbench

- Iterative 64-bit multiply/divide unit on the execute side of the datapath.
- Consumes register-file read buses (BusA, BusB) and produces a write-back value, destination index and write strobe for the register file's BusW/RW/RegWr inputs.
- Supports the LEGv8 MUL, UMULH, SMULH, UDIV and SDIV ops.
- Fixed latency; one radix-2 step per clock.

---
 rtl/mul_div_unit.sv | 161 ++++++++++++++++
 tb/tb_mul_div_unit.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - iterative radix-2 MUL/UMULH/SMULH/UDIV/SDIV unit for the execute stage
// Optional zero-operand early-out is built when MULDIV_EARLY_OUT_EN is defined.
module mul_div_unit #(
    parameter int WIDTH = 64
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [2:0]       Op,
    input  logic [WIDTH-1:0] BusA,
    input  logic [WIDTH-1:0] BusB,
    input  logic [4:0]       DestReg,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Result,
    output logic [4:0]       RW,
    output logic             RegWr
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    localparam logic [2:0] OP_MUL   = 3'b000;
    localparam logic [2:0] OP_UMULH = 3'b001;
    localparam logic [2:0] OP_SMULH = 3'b010;
    localparam logic [2:0] OP_UDIV  = 3'b011;
    localparam logic [2:0] OP_SDIV  = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CALC  = 2'd1,
        ST_FIXUP = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [2:0]           r_op;
    logic [4:0]           r_rw;
    logic [CW-1:0]        r_cnt;
    logic [2*WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]     r_b;
    logic                 r_neg;
    logic [WIDTH-1:0]     r_result;

    logic                 w_signed;
    logic                 w_a_neg;
    logic                 w_b_neg;
    logic [WIDTH-1:0]     w_a_mag;
    logic [WIDTH-1:0]     w_b_mag;
    logic                 w_is_div;
    logic                 w_early;
    logic [WIDTH:0]       w_sum;
    logic [2*WIDTH-1:0]   w_mul_next;
    logic [WIDTH:0]       w_rem_sh;
    logic [WIDTH:0]       w_diff;
    logic                 w_ge;
    logic [2*WIDTH-1:0]   w_div_next;
    logic [2*WIDTH-1:0]   w_prod_fix;
    logic [WIDTH-1:0]     w_quot_fix;
    logic [WIDTH-1:0]     w_result_fix;

    // Operand conditioning: signed ops work on magnitudes and remember the result sign.
    assign w_signed = (Op == OP_SMULH) || (Op == OP_SDIV);
    assign w_a_neg  = w_signed && BusA[WIDTH-1];
    assign w_b_neg  = w_signed && BusB[WIDTH-1];
    assign w_a_mag  = w_a_neg ? (~BusA + 1'b1) : BusA;
    assign w_b_mag  = w_b_neg ? (~BusB + 1'b1) : BusB;
    assign w_is_div = (r_op == OP_UDIV) || (r_op == OP_SDIV);

`ifdef MULDIV_EARLY_OUT_EN
    assign w_early = (Op <= OP_SDIV) && ((BusA == '0) || (BusB == '0));
`else
    assign w_early = 1'b0;
`endif

    // Multiply step: accumulator holds {partial product, remaining multiplier bits}.
    assign w_sum      = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, (r_acc[0] ? r_b : {WIDTH{1'b0}})};
    assign w_mul_next = {w_sum, r_acc[WIDTH-1:1]};

    // Divide step: accumulator holds {partial remainder, dividend bits / quotient bits}.
    assign w_rem_sh   = r_acc[2*WIDTH-1:WIDTH-1];
    assign w_diff     = w_rem_sh - {1'b0, r_b};
    assign w_ge       = ~w_diff[WIDTH];
    assign w_div_next = {(w_ge ? w_diff[WIDTH-1:0] : w_rem_sh[WIDTH-1:0]), r_acc[WIDTH-2:0], w_ge};

    assign w_prod_fix = r_neg ? (~r_acc + 1'b1) : r_acc;
    assign w_quot_fix = r_neg ? (~r_acc[WIDTH-1:0] + 1'b1) : r_acc[WIDTH-1:0];

    always_comb begin
        w_result_fix = '0;
        case (r_op)
            OP_MUL:            w_result_fix = r_acc[WIDTH-1:0];
            OP_UMULH:          w_result_fix = r_acc[2*WIDTH-1:WIDTH];
            OP_SMULH:          w_result_fix = w_prod_fix[2*WIDTH-1:WIDTH];
            OP_UDIV, OP_SDIV:  w_result_fix = (r_b == '0) ? '0 : w_quot_fix;
            default:           w_result_fix = '0;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (Start) w_state_next = w_early ? ST_DONE : ST_CALC;
            ST_CALC:  if (r_cnt == CNT_LAST) w_state_next = ST_FIXUP;
            ST_FIXUP: w_state_next = ST_DONE;
            ST_DONE:  w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        Busy  = (r_state != ST_IDLE);
        Done  = (r_state == ST_DONE);
        RegWr = (r_state == ST_DONE) && (r_rw != 5'd31);
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_op     <= '0;
            r_rw     <= '0;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_b      <= '0;
            r_neg    <= 1'b0;
            r_result <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (Start) begin
                        r_op  <= Op;
                        r_rw  <= DestReg;
                        r_cnt <= '0;
                        r_acc <= {{WIDTH{1'b0}}, w_a_mag};
                        r_b   <= w_b_mag;
                        r_neg <= w_a_neg ^ w_b_neg;
                        if (w_early) r_result <= '0;
                    end
                end
                ST_CALC: begin
                    r_acc <= w_is_div ? w_div_next : w_mul_next;
                    r_cnt <= r_cnt + 1'b1;
                end
                ST_FIXUP: r_result <= w_result_fix;
                default: ;
            endcase
        end
    end

    assign Result = r_result;
    assign RW     = r_rw;

endmodule

// File: tb/tb_mul_div_unit.sv
// tb/tb_mul_div_unit.sv - directed self-checking bench for mul_div_unit
module tb_mul_div_unit;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        Start = 1'b0;
    logic [2:0]  Op = 3'b000;
    logic [63:0] BusA = '0;
    logic [63:0] BusB = '0;
    logic [4:0]  DestReg = '0;
    logic        Busy;
    logic        Done;
    logic [63:0] Result;
    logic [4:0]  RW;
    logic        RegWr;

    int n_checks = 0;
    int n_fail   = 0;

    localparam int LAT_FULL = 66;
`ifdef MULDIV_EARLY_OUT_EN
    localparam int LAT_ZERO = 1;
`else
    localparam int LAT_ZERO = 66;
`endif

    mul_div_unit #(.WIDTH(64)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Op(Op), .BusA(BusA), .BusB(BusB),
        .DestReg(DestReg), .Busy(Busy), .Done(Done), .Result(Result), .RW(RW), .RegWr(RegWr)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic launch(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                          input logic [4:0] dest);
        Op = op; BusA = a; BusB = b; DestReg = dest; Start = 1'b1;
        @(posedge Clk); #1;
        Start = 1'b0;
        BusA = 64'hDEAD_BEEF_0BAD_F00D;
        BusB = 64'h1234_5678_9ABC_DEF0;
        DestReg = 5'd17;
        Op = 3'b001;
    endtask

    task automatic run_op(input string tag, input logic [2:0] op, input logic [63:0] a,
                          input logic [63:0] b, input logic [4:0] dest, input logic [63:0] exp_res,
                          input logic exp_regwr, input int exp_lat);
        int lat;
        launch(op, a, b, dest);
        check({tag, " busy"}, Busy, 1'b1);
        lat = 1;
        while (!Done && lat < 200) begin
            @(posedge Clk); #1;
            lat++;
        end
        check({tag, " latency"}, lat, exp_lat);
        check({tag, " result"}, Result, exp_res);
        check({tag, " rw"}, RW, dest);
        check({tag, " regwr"}, RegWr, exp_regwr);
        @(negedge Clk);
        check({tag, " result@negedge"}, Result, exp_res);
        @(posedge Clk); #1;
        check({tag, " done drop"}, Done, 1'b0);
        check({tag, " regwr drop"}, RegWr, 1'b0);
        check({tag, " idle"}, Busy, 1'b0);
    endtask

    initial begin
        int dones;
        int first_done;

        repeat (3) @(posedge Clk);
        #1;
        check("reset busy", Busy, 1'b0);
        check("reset done", Done, 1'b0);
        check("reset regwr", RegWr, 1'b0);
        check("reset result", Result, 64'd0);
        check("reset rw", RW, 5'd0);
        Reset = 1'b0;
        @(posedge Clk); #1;

        run_op("mul", 3'b000, 64'd7, 64'd6, 5'd5, 64'd42, 1'b1, LAT_FULL);
        run_op("mul wrap", 3'b000, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd3, 64'd1, 1'b1, LAT_FULL);
        run_op("umulh", 3'b001, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd1, 64'd1, 1'b1, LAT_FULL);
        run_op("smulh", 3'b010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd2, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, LAT_FULL);
        run_op("sdiv", 3'b100, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 5'd4, 64'hFFFF_FFFF_FFFF_FFF2, 1'b1, LAT_FULL);
        run_op("sdiv ovf", 3'b100, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd6,
               64'h8000_0000_0000_0000, 1'b1, LAT_FULL);
        run_op("udiv0", 3'b011, 64'd100, 64'd0, 5'd7, 64'd0, 1'b1, LAT_ZERO);
        run_op("udiv r31", 3'b011, 64'd100, 64'd7, 5'd31, 64'd14, 1'b0, LAT_FULL);
        run_op("illegal", 3'b110, 64'd9, 64'd9, 5'd8, 64'd0, 1'b1, LAT_FULL);

        // Abort mid-operation with an asynchronous reset.
        launch(3'b000, 64'd7, 64'd6, 5'd5);
        repeat (29) @(posedge Clk);
        #2;
        Reset = 1'b1;
        #1;
        check("abort busy", Busy, 1'b0);
        check("abort done", Done, 1'b0);
        check("abort result", Result, 64'd0);
        check("abort rw", RW, 5'd0);
        @(posedge Clk); #1;
        Reset = 1'b0;
        dones = 0;
        for (int i = 0; i < 80; i++) begin
            @(posedge Clk); #1;
            if (Done) dones++;
        end
        check("abort no done", dones, 0);

        run_op("restart", 3'b000, 64'd7, 64'd6, 5'd5, 64'd42, 1'b1, LAT_FULL);

        // A Start raised while busy must be ignored.
        launch(3'b000, 64'd7, 64'd6, 5'd5);
        dones = 0;
        first_done = 0;
        for (int c = 1; c <= 150; c++) begin
            if (c == 10) begin
                Op = 3'b001; BusA = 64'hFFFF_FFFF_FFFF_FFFF; BusB = 64'd2; DestReg = 5'd9; Start = 1'b1;
            end
            if (c == 11) Start = 1'b0;
            if (Done) begin
                dones++;
                if (first_done == 0) begin
                    first_done = c;
                    check("busy start result", Result, 64'd42);
                    check("busy start rw", RW, 5'd5);
                end
            end
            @(posedge Clk); #1;
        end
        check("busy start done count", dones, 1);
        check("busy start latency", first_done, LAT_FULL);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
